// File: rtl/mem_arb_pkg.sv
// Shared types for memory-port arbiters: FSM state and latched command kind.
package mem_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    typedef enum logic {ARB_OP_READ, ARB_OP_WRITE} arb_op_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bundle of the memory port arbiter.
// master = requesters plus memory model, slave = the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256
);
    logic [NUM_PORTS-1:0]             read_i;
    logic [NUM_PORTS-1:0]             write_i;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] address_i;
    logic [NUM_PORTS-1:0][LINE_W-1:0] wdata_i;
    logic [NUM_PORTS-1:0]             resp_o;
    logic [LINE_W-1:0]                rdata_o;
    logic                             mem_read;
    logic                             mem_write;
    logic [ADDR_W-1:0]                mem_address;
    logic [LINE_W-1:0]                mem_wdata;
    logic                             mem_resp;
    logic [LINE_W-1:0]                mem_rdata;

    modport master (
        output read_i, write_i, address_i, wdata_i, mem_resp, mem_rdata,
        input  resp_o, rdata_o, mem_read, mem_write, mem_address, mem_wdata
    );

    modport slave (
        input  read_i, write_i, address_i, wdata_i, mem_resp, mem_rdata,
        output resp_o, rdata_o, mem_read, mem_write, mem_address, mem_wdata
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational priority picker: first set request at or after ptr (wrapping)
// when rr_en, otherwise the lowest set index.
module rr_priority_pick #(
    parameter int  NUM_PORTS = 2,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    input  logic                 rr_en,
    output logic                 valid,
    output logic [IDX_W-1:0]     idx
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    assign valid = |req;

    // Walk ports in search order and keep the first requester found.
    always_comb begin
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand     = rr_en ? (int'(ptr) + i) % NUM_PORTS : i;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port cache-line arbiter in front of a single memory port. One port is
// granted at a time; its command is latched and held until mem_resp.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256,
    parameter bit RR_EN     = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    arb_state_t           state;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_PORTS-1:0] req;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    arb_op_t              pick_op;

    assign req = bus.read_i | bus.write_i;

    rr_priority_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .rr_en (RR_EN),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A port asserting both read and write gets its write issued.
    assign pick_op = bus.write_i[pick_idx] ? ARB_OP_WRITE : ARB_OP_READ;

    // Arbitration FSM: latch the winner's command in IDLE, hold it until mem_resp.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ARB_IDLE;
            grant           <= '0;
            rr_ptr          <= '0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_wdata   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state           <= ARB_BUSY;
                        grant           <= pick_idx;
                        bus.mem_write   <= (pick_op == ARB_OP_WRITE);
                        bus.mem_read    <= (pick_op == ARB_OP_READ);
                        bus.mem_address <= ADDR_W'(bus.address_i[pick_idx]);
                        bus.mem_wdata   <= LINE_W'(bus.wdata_i[pick_idx]);
                    end
                end
                ARB_BUSY: begin
                    if (bus.mem_resp) begin
                        state         <= ARB_IDLE;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        rr_ptr        <= (grant == IDX_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Done pulse goes only to the granted port, and only while a transaction is open.
    always_comb begin
        bus.resp_o = '0;
        if (state == ARB_BUSY) bus.resp_o[grant] = bus.mem_resp;
    end

    assign bus.rdata_o = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences on 2-port
// round-robin and fixed-priority instances, a vector table and randomized
// transactions on a 4-port round-robin instance.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW)) if2r ();
    mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW)) if2f ();
    mem_port_arbiter_if #(.NUM_PORTS(4), .ADDR_W(AW), .LINE_W(LW)) if4r ();

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW), .RR_EN(1'b1)) u2r (
        .clk(clk), .rst_n(rst_n), .bus(if2r.slave));
    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW), .RR_EN(1'b0)) u2f (
        .clk(clk), .rst_n(rst_n), .bus(if2f.slave));
    mem_port_arbiter #(.NUM_PORTS(4), .ADDR_W(AW), .LINE_W(LW), .RR_EN(1'b1)) u4r (
        .clk(clk), .rst_n(rst_n), .bus(if4r.slave));

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        int         exp_port;
        logic       exp_write;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference rule: visit ports starting at ptr, wrapping, first requester wins.
    function automatic int rr_winner(input logic [3:0] req, input int ptr);
        int order[$];
        for (int k = ptr; k < 4; k++) order.push_back(k);
        for (int k = 0; k < ptr; k++) order.push_back(k);
        foreach (order[j]) if (req[order[j]]) return order[j];
        return -1;
    endfunction

    function automatic logic [AW-1:0] tbl_addr(input int e, input int p);
        return AW'(32'h0001_0000 * (e + 1) + 32'h10 * p);
    endfunction

    function automatic logic [LW-1:0] tbl_wdata(input int e, input int p);
        return LW'(32'hC0DE_0000 + 4 * e + p);
    endfunction

    task automatic clear_all();
        if2r.read_i = '0; if2r.write_i = '0; if2r.address_i = '0; if2r.wdata_i = '0;
        if2r.mem_resp = 1'b0; if2r.mem_rdata = '0;
        if2f.read_i = '0; if2f.write_i = '0; if2f.address_i = '0; if2f.wdata_i = '0;
        if2f.mem_resp = 1'b0; if2f.mem_rdata = '0;
        if4r.read_i = '0; if4r.write_i = '0; if4r.address_i = '0; if4r.wdata_i = '0;
        if4r.mem_resp = 1'b0; if4r.mem_rdata = '0;
    endtask

    initial begin
        logic [LW-1:0] line;
        logic [LW-1:0] exp_wdata;
        logic [AW-1:0] exp_addr;
        logic [3:0]    rd, wr, er;
        int            model_ptr, wp, lat, exp_r;
        logic          ew;

        tbl[0] = '{4'b0010, 4'b0000, 1, 1'b0};
        tbl[1] = '{4'b0001, 4'b0100, 2, 1'b1};
        tbl[2] = '{4'b0101, 4'b0000, 0, 1'b0};
        tbl[3] = '{4'b1111, 4'b0000, 1, 1'b0};
        tbl[4] = '{4'b0000, 4'b1000, 3, 1'b1};
        tbl[5] = '{4'b0001, 4'b0001, 0, 1'b1};
        tbl[6] = '{4'b1000, 4'b0001, 3, 1'b0};
        tbl[7] = '{4'b0100, 4'b1000, 2, 1'b0};

        // Reset state
        clear_all();
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_2r_mem_read", if2r.mem_read, 0);
        chk("rst_2r_mem_write", if2r.mem_write, 0);
        chk("rst_2r_mem_address", if2r.mem_address, 0);
        chk("rst_2r_mem_wdata", if2r.mem_wdata, 0);
        chk("rst_2f_mem_read", if2f.mem_read, 0);
        chk("rst_4r_mem_write", if4r.mem_write, 0);
        chk("rst_4r_resp", if4r.resp_o, 0);
        rst_n = 1'b1;

        // Single read on port 1
        if2r.read_i = 2'b10;
        if2r.address_i[1] = 32'h100;
        tick();
        chk("t1_mem_read", if2r.mem_read, 1);
        chk("t1_mem_write", if2r.mem_write, 0);
        chk("t1_mem_address", if2r.mem_address, 32'h100);
        if2r.mem_resp = 1'b1;
        line = {8{32'hA5A5_A5A5}};
        if2r.mem_rdata = line;
        #2;
        chk("t1_resp", if2r.resp_o, 2'b10);
        chk("t1_rdata", if2r.rdata_o, line);
        tick();
        if2r.mem_resp = 1'b0;
        if2r.read_i = '0;
        chk("t1_idle_read", if2r.mem_read, 0);

        // Two held requesters; round-robin alternates, fixed priority always takes 0
        if2r.read_i = 2'b01; if2r.write_i = 2'b10;
        if2r.address_i[0] = 32'h200; if2r.address_i[1] = 32'h300;
        if2r.wdata_i[1] = {8{32'h1234_5678}};
        if2f.read_i = 2'b01; if2f.write_i = 2'b10;
        if2f.address_i[0] = 32'h200; if2f.address_i[1] = 32'h300;
        for (int t = 0; t < 4; t++) begin
            tick();
            exp_r = t % 2;
            chk("t2_rr_write", if2r.mem_write, exp_r == 1);
            chk("t2_rr_read", if2r.mem_read, exp_r == 0);
            chk("t2_rr_addr", if2r.mem_address, exp_r == 1 ? 32'h300 : 32'h200);
            chk("t2_fix_read", if2f.mem_read, 1);
            chk("t2_fix_addr", if2f.mem_address, 32'h200);
            tick(); tick(); tick();
            if2r.mem_resp = 1'b1; if2f.mem_resp = 1'b1;
            #2;
            chk("t2_rr_resp", if2r.resp_o, exp_r == 1 ? 2'b10 : 2'b01);
            chk("t2_fix_resp", if2f.resp_o, 2'b01);
            tick();
            if2r.mem_resp = 1'b0; if2f.mem_resp = 1'b0;
            chk("t2_rr_bubble", if2r.mem_read | if2r.mem_write, 0);
            chk("t2_fix_bubble", if2f.mem_read | if2f.mem_write, 0);
        end
        if2r.read_i = '0; if2r.write_i = '0;
        if2f.read_i = '0; if2f.write_i = '0;

        // Requester changes address and drops request while BUSY
        if2r.read_i = 2'b10;
        if2r.address_i[1] = 32'h440;
        tick();
        chk("t5_mem_read", if2r.mem_read, 1);
        chk("t5_addr", if2r.mem_address, 32'h440);
        if2r.address_i[1] = 32'hDEAD_0000;
        if2r.read_i = '0;
        tick();
        chk("t5_addr_hold", if2r.mem_address, 32'h440);
        chk("t5_read_hold", if2r.mem_read, 1);
        chk("t5_no_early_resp", if2r.resp_o, 0);
        if2r.mem_resp = 1'b1;
        #2;
        chk("t5_resp", if2r.resp_o, 2'b10);
        tick();
        if2r.mem_resp = 1'b0;
        chk("t5_done", if2r.mem_read, 0);

        // Reset mid-transaction, then responses with nothing outstanding
        if2r.read_i = 2'b01;
        if2r.address_i[0] = 32'h500;
        tick();
        chk("t6_busy", if2r.mem_read, 1);
        rst_n = 1'b0;
        if2r.read_i = '0;
        tick();
        chk("t6_rst_read", if2r.mem_read, 0);
        chk("t6_rst_addr", if2r.mem_address, 0);
        rst_n = 1'b1;
        if2r.mem_resp = 1'b1;
        #2;
        chk("t6_resp_after_rst", if2r.resp_o, 0);
        tick();
        chk("t6_idle_resp", if2r.resp_o, 0);
        chk("t6_idle_read", if2r.mem_read, 0);
        if2r.mem_resp = 1'b0;

        // Vector table on the 4-port round-robin instance
        for (int e = 0; e < 8; e++) begin
            if4r.read_i  = tbl[e].rd;
            if4r.write_i = tbl[e].wr;
            for (int p = 0; p < 4; p++) begin
                if4r.address_i[p] = tbl_addr(e, p);
                if4r.wdata_i[p]   = tbl_wdata(e, p);
            end
            tick();
            chk("tbl_mem_write", if4r.mem_write, tbl[e].exp_write);
            chk("tbl_mem_read", if4r.mem_read, !tbl[e].exp_write);
            chk("tbl_mem_address", if4r.mem_address, tbl_addr(e, tbl[e].exp_port));
            chk("tbl_mem_wdata", if4r.mem_wdata, tbl_wdata(e, tbl[e].exp_port));
            line = rand_line();
            if4r.mem_resp = 1'b1;
            if4r.mem_rdata = line;
            #2;
            er = '0;
            er[tbl[e].exp_port] = 1'b1;
            chk("tbl_resp", if4r.resp_o, er);
            chk("tbl_rdata", if4r.rdata_o, line);
            tick();
            if4r.mem_resp = 1'b0;
            if4r.read_i = '0; if4r.write_i = '0;
            chk("tbl_bubble", if4r.mem_read | if4r.mem_write, 0);
            chk("tbl_bubble_resp", if4r.resp_o, 0);
        end

        // Randomized transactions against the reference rule
        model_ptr = (tbl[7].exp_port + 1) % 4;
        for (int it = 0; it < 150; it++) begin
            rd = 4'($urandom_range(0, 15));
            wr = 4'($urandom_range(0, 15));
            if ((rd | wr) == 4'b0) rd[$urandom_range(0, 3)] = 1'b1;
            if4r.read_i = rd; if4r.write_i = wr;
            for (int p = 0; p < 4; p++) begin
                if4r.address_i[p] = $urandom;
                if4r.wdata_i[p]   = rand_line();
            end
            wp = rr_winner(rd | wr, model_ptr);
            ew = wr[wp];
            exp_addr  = if4r.address_i[wp];
            exp_wdata = if4r.wdata_i[wp];
            tick();
            if4r.mem_resp = 1'b0;
            chk("rnd_mem_write", if4r.mem_write, ew);
            chk("rnd_mem_read", if4r.mem_read, !ew);
            chk("rnd_mem_address", if4r.mem_address, exp_addr);
            chk("rnd_mem_wdata", if4r.mem_wdata, exp_wdata);
            lat = $urandom_range(0, 3);
            for (int c = 0; c < lat; c++) begin
                if4r.read_i  = 4'($urandom_range(0, 15));
                if4r.write_i = 4'($urandom_range(0, 15));
                for (int p = 0; p < 4; p++) if4r.address_i[p] = $urandom;
                #2;
                chk("rnd_wait_resp", if4r.resp_o, 0);
                tick();
                chk("rnd_hold_addr", if4r.mem_address, exp_addr);
                chk("rnd_hold_op", {if4r.mem_write, if4r.mem_read}, {ew, !ew});
            end
            line = rand_line();
            if4r.mem_resp = 1'b1;
            if4r.mem_rdata = line;
            #2;
            er = '0;
            er[wp] = 1'b1;
            chk("rnd_resp", if4r.resp_o, er);
            chk("rnd_rdata", if4r.rdata_o, line);
            tick();
            model_ptr = (wp + 1) % 4;
            if4r.read_i = '0; if4r.write_i = '0;
            if4r.mem_resp = 1'($urandom_range(0, 1));
            #2;
            chk("rnd_bubble_op", if4r.mem_read | if4r.mem_write, 0);
            chk("rnd_bubble_resp", if4r.resp_o, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
